mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the core's fetch stage and load/store stage.
- Arbitrates fixed-priority-to-data with a fetch anti-starvation bound, sequences each memory access through a fixed-latency FSM, and returns read data and a one-cycle ready pulse to the winning requester.
- Sits between the pipeline front/back ends and the memory macro inside the top-level processor.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte enables are DATA_W/8 bits.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid. Legal range is 1 or more.
- STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced. Legal range is 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data; valid when if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 when FSM state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; starve counter cleared.
  - All outputs are 0, including if_rdata and d_rdata.
  - Applies mid-transaction: the in-flight access is abandoned and no ready pulse is generated.
- FSM states: IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles; skipped when MEM_LAT=1) -> CAPT -> RESP -> IDLE.
- IDLE arbitration, evaluated at the clock edge:
  - Grant data if d_req=1 and (if_req=0 or starve_cnt < STARVE_MAX).
  - Otherwise grant fetch if if_req=1.
  - Otherwise stay in IDLE.
- Grant capture: the winner's address, we, wdata and be are registered into the mem_* outputs and the winner ID is latched. Requester input changes after grant are ignored.
- Fetch access drives mem_we=0 and mem_be=all ones; mem_wdata is don't-care and is driven 0.
- ISSUE: mem_en=1 for exactly this cycle. mem_addr, mem_we, mem_be and mem_wdata stay stable from ISSUE through CAPT.
- CAPT: the cycle that is MEM_LAT cycles after ISSUE. mem_rdata is registered into the winner's rdata output on this edge, for loads and fetches only. For stores, d_rdata keeps its previous value.
- RESP: the winner's ready=1 for exactly one cycle. The non-winner's ready and rdata are unchanged.
- Arbitration resumes in the IDLE cycle after RESP. A request still high during RESP is never regranted in that cycle.
- Timing:
  - A request sampled at edge E0 gives ISSUE in cycle 1, rdata valid in cycle 1+MEM_LAT, and ready in cycle 2+MEM_LAT.
  - Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each data grant made while if_req=1.
  - Clears on a fetch grant, or in any IDLE cycle where if_req=0.
- Simultaneous requests: with starve_cnt < STARVE_MAX, data wins. With starve_cnt = STARVE_MAX, fetch wins.
- Requester deasserts req before ready: the transaction still completes and the ready pulse still fires.
- Addresses pass through unmodified; no alignment checking.
- if_rdata and d_rdata hold their last captured values between transactions.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Single fetch: if_req=1, if_addr=0x10, memory word 0x00A00093 -> mem_en high cycle 1 with mem_addr=0x10, mem_be=0xF, mem_we=0; if_ready=1 and if_rdata=0x00A00093 in cycle 4; busy low again in cycle 5.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF, d_ready seen; then load from 0x40 -> d_rdata=0xDEADBEEF on d_ready. if_rdata unchanged throughout.
- Simultaneous requests: if_req and d_req high together at E0 -> data granted first (d_ready cycle 4), fetch ISSUE in cycle 6, if_ready cycle 9.
- Starvation: if_req held high, d_req held high continuously -> exactly 4 data grants, then 1 fetch grant, then data resumes. The pattern repeats D,D,D,D,F.
- Reset mid-op: drop reset to 0 in the WAIT cycle of a load -> all outputs 0 immediately; no d_ready after release. A new request after release completes with normal timing.
- Early deassert and input churn: d_req dropped and d_addr changed to 0x99 the cycle after grant -> mem_addr keeps the original value and d_ready still pulses in cycle 4.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// stage and the load/store stage of the core.
//
// Arbitration happens only in IDLE. Data wins by default. Fetch is forced
// once STARVE_MAX data grants have been made back to back while fetch was
// waiting. Each access then runs through a fixed-latency sequence:
//
//   IDLE -> ISSUE -> WAIT (MEM_LAT-1 cycles, absent when MEM_LAT=1)
//        -> CAPT -> RESP -> IDLE
//
// ISSUE is the only cycle with mem_en=1. The memory returns data in CAPT,
// which is MEM_LAT cycles after ISSUE. That data is registered into the
// winner's rdata output at the end of CAPT, so rdata and the one-cycle
// ready pulse appear together in RESP.
//
// A request sampled at edge E0 therefore gives:
//   ISSUE in cycle 1, memory data in cycle 1+MEM_LAT, ready in cycle 2+MEM_LAT.
// One transaction takes MEM_LAT+3 cycles, counting the IDLE cycle in which
// the next grant is made.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width; byte enables are DATA_W/8 bits
//   MEM_LAT     cycles from the mem_en cycle to valid mem_rdata (>= 1)
//   STARVE_MAX  data grants allowed while fetch waits before fetch is forced (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   if_req     in   fetch request, held until if_ready
//   if_addr    in   fetch address
//   if_rdata   out  fetch read data, valid with if_ready, held afterwards
//   if_ready   out  one-cycle fetch completion pulse
//   d_req      in   data request, held until d_ready
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data address
//   d_wdata    in   store data
//   d_be       in   store byte enables
//   d_rdata    out  load data, valid with d_ready, held afterwards
//   d_ready    out  one-cycle data completion pulse
//   mem_en     out  memory access strobe, one cycle per transaction
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_be     out  memory byte enables
//   mem_rdata  in   memory read data
//   busy       out  high whenever the sequencer is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    // Fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,

    // Load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,

    // Memory macro
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_e;

    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_DATA  = 1'b1
    } winner_e;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_e              state_q;
    winner_e             winner_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic [CNT_W-1:0]    starve_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q;

    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BE_W-1:0]     mem_be_q;

    logic [DATA_W-1:0]   if_rdata_q;
    logic                if_ready_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                d_ready_q;

    // -----------------------------------------------------------------------
    // IDLE arbitration and starve counter next state
    // -----------------------------------------------------------------------
    logic in_idle;
    logic fetch_starved;
    logic gnt_data;
    logic gnt_fetch;

    assign in_idle       = (state_q == S_IDLE);
    assign fetch_starved = (starve_cnt_q >= CNT_W'(STARVE_MAX));

    // Data wins unless fetch is waiting and has already been passed over
    // STARVE_MAX times in a row.
    assign gnt_data  = in_idle && d_req && (!if_req || !fetch_starved);
    assign gnt_fetch = in_idle && if_req && !gnt_data;

    // NOTE: every signal written in an always_comb block gets a default
    // assignment first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt_data && if_req) begin
            // A data grant passed over a waiting fetch. Count it, saturating.
            if (!fetch_starved) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (gnt_fetch) begin
            starve_cnt_d = '0;
        end else if (in_idle && !if_req) begin
            // Fetch is no longer waiting, so its starvation history is void.
            starve_cnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer: grant capture, access timing, response generation
    // -----------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments. Every
    // register therefore samples the pre-edge value of every other register,
    // whatever order the statements appear in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            winner_q     <= WIN_FETCH;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;

            // The strobe and the ready pulses each last one cycle. They are
            // cleared by default and set only on the edge that enters
            // ISSUE or RESP.
            mem_en_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (gnt_data) begin
                        winner_q    <= WIN_DATA;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                        state_q     <= S_ISSUE;
                    end else if (gnt_fetch) begin
                        winner_q    <= WIN_FETCH;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (MEM_LAT > 1) begin
                        // The counter is loaded one short because the first
                        // WAIT cycle is spent while it reads MEM_LAT-2.
                        wait_cnt_q <= WAIT_W'(MEM_LAT - 2);
                        state_q    <= S_WAIT;
                    end else begin
                        state_q    <= S_CAPT;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= S_CAPT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end

                S_CAPT: begin
                    // Only reads update rdata. A store leaves the last load
                    // data visible on d_rdata.
                    if (winner_q == WIN_FETCH) begin
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_ready_q <= 1'b1;
                    end
                    state_q <= S_RESP;
                end

                S_RESP: begin
                    // No grant is made here. A request still high during
                    // RESP is arbitrated in the following IDLE cycle.
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;

    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with MEM_LAT=2 and STARVE_MAX=4.
//
// The memory model is a small word array indexed by address bits [9:2].
// Writes honour the byte enables. Read data is returned exactly two cycles
// after the mem_en cycle. In every other cycle mem_rdata carries a poison
// value, so capturing in the wrong cycle shows up as wrong data.
//
// Inputs are driven on the falling edge and outputs are sampled there too.
// Each tick() advances to the middle of the next cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected held values of the two rdata outputs.
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (2),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Memory model
    // -----------------------------------------------------------------------
    logic [31:0] mem [0:255];
    logic        preload;
    logic        rd_v1, rd_v2;
    logic [31:0] rd_d1, rd_d2;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h00A0_0093;            // word at byte address 0x10
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_v1 <= mem_en && !mem_we;
        rd_d1 <= mem[mem_addr[9:2]];
        rd_v2 <= rd_v1;
        rd_d2 <= rd_d1;
    end

    assign mem_rdata = rd_v2 ? rd_d2 : POISON;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Fetch transaction from an idle arbiter, checked cycle by cycle.
    task automatic fetch_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp_rdata);
        if_req  = 1'b1;
        if_addr = addr;
        tick();                                             // cycle 1: ISSUE
        check({tag, "_en"},    {31'b0, mem_en}, 32'd1);
        check({tag, "_addr"},  mem_addr, addr);
        check({tag, "_we"},    {31'b0, mem_we}, 32'd0);
        check({tag, "_be"},    {28'b0, mem_be}, 32'hF);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_busy"},  {31'b0, busy}, 32'd1);
        tick();                                             // cycle 2: WAIT
        check({tag, "_en_once"}, {31'b0, mem_en}, 32'd0);
        check({tag, "_addr_hold"}, mem_addr, addr);
        tick();                                             // cycle 3: CAPT
        check({tag, "_early_rdy"}, {31'b0, if_ready}, 32'd0);
        tick();                                             // cycle 4: RESP
        check({tag, "_rdy"},    {31'b0, if_ready}, 32'd1);
        check({tag, "_rdata"},  if_rdata, exp_rdata);
        check({tag, "_d_rdy"},  {31'b0, d_ready}, 32'd0);
        check({tag, "_d_hold"}, d_rdata, exp_d_rdata);
        exp_if_rdata = exp_rdata;
        if_req = 1'b0;
        tick();                                             // cycle 5: IDLE
        check({tag, "_idle"},   {31'b0, busy}, 32'd0);
        check({tag, "_pulse"},  {31'b0, if_ready}, 32'd0);
        check({tag, "_held"},   if_rdata, exp_rdata);
    endtask

    // Data transaction from an idle arbiter. For stores exp_rdata is the
    // value d_rdata must still hold.
    task automatic data_txn(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_be    = be;
        tick();                                             // cycle 1
        check({tag, "_en"},    {31'b0, mem_en}, 32'd1);
        check({tag, "_addr"},  mem_addr, addr);
        check({tag, "_we"},    {31'b0, mem_we}, {31'b0, we});
        check({tag, "_be"},    {28'b0, mem_be}, {28'b0, be});
        check({tag, "_wdata"}, mem_wdata, wdata);
        tick();                                             // cycle 2
        check({tag, "_en_once"}, {31'b0, mem_en}, 32'd0);
        tick();                                             // cycle 3
        check({tag, "_early_rdy"}, {31'b0, d_ready}, 32'd0);
        tick();                                             // cycle 4
        check({tag, "_rdy"},     {31'b0, d_ready}, 32'd1);
        check({tag, "_rdata"},   d_rdata, exp_rdata);
        check({tag, "_if_rdy"},  {31'b0, if_ready}, 32'd0);
        check({tag, "_if_hold"}, if_rdata, exp_if_rdata);
        exp_d_rdata = exp_rdata;
        d_req = 1'b0;
        tick();                                             // cycle 5
        check({tag, "_idle"},  {31'b0, busy}, 32'd0);
        check({tag, "_pulse"}, {31'b0, d_ready}, 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [9:0] starve_pat;

    initial begin
        reset   = 1'b0;
        preload = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;

        // Reset state
        tick();
        preload = 1'b0;
        tick();
        check("rst_busy",     {31'b0, busy},     32'd0);
        check("rst_mem_en",   {31'b0, mem_en},   32'd0);
        check("rst_mem_addr", mem_addr,          32'h0);
        check("rst_mem_be",   {28'b0, mem_be},   32'h0);
        check("rst_if_rdy",   {31'b0, if_ready}, 32'd0);
        check("rst_d_rdy",    {31'b0, d_ready},  32'd0);
        check("rst_if_rdata", if_rdata,          32'h0);
        check("rst_d_rdata",  d_rdata,           32'h0);
        reset = 1'b1;
        tick();

        // Single fetch
        fetch_txn("fetch", 32'h10, 32'h00A0_0093);

        // Store then load, then a partial store that must not touch d_rdata
        data_txn("st40", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0);
        data_txn("ld40", 1'b0, 32'h40, 32'h0,         4'hF, 32'hDEAD_BEEF);
        data_txn("st44", 1'b1, 32'h44, 32'h1234_5678, 4'h3, 32'hDEAD_BEEF);
        data_txn("ld44", 1'b0, 32'h44, 32'h0,         4'hF, 32'h0000_5678);

        // Simultaneous requests: data first, fetch next
        if_req = 1'b1; if_addr = 32'h10;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF; d_wdata = 32'h0;
        tick();                                             // cycle 1
        check("sim_first_addr", mem_addr, 32'h40);
        tick(); tick(); tick();                             // cycle 4
        check("sim_d_rdy",   {31'b0, d_ready},  32'd1);
        check("sim_d_rdata", d_rdata,           32'hDEAD_BEEF);
        check("sim_if_wait", {31'b0, if_ready}, 32'd0);
        d_req = 1'b0;
        tick();                                             // cycle 5
        check("sim_idle", {31'b0, busy},   32'd0);
        check("sim_gap",  {31'b0, mem_en}, 32'd0);
        tick();                                             // cycle 6
        check("sim_f_en",   {31'b0, mem_en}, 32'd1);
        check("sim_f_addr", mem_addr,        32'h10);
        tick(); tick();                                     // cycle 8
        check("sim_f_early", {31'b0, if_ready}, 32'd0);
        tick();                                             // cycle 9
        check("sim_f_rdy",   {31'b0, if_ready}, 32'd1);
        check("sim_f_rdata", if_rdata,          32'h00A0_0093);
        if_req = 1'b0;
        tick();
        exp_d_rdata = 32'hDEAD_BEEF;

        // Starvation: both held high, grants follow D,D,D,D,F,D,D,D,D,F
        starve_pat = 10'b10_0001_0000;
        if_req = 1'b1; if_addr = 32'h10;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            tick();                                         // ISSUE
            check($sformatf("starve%0d_en", i),   {31'b0, mem_en}, 32'd1);
            check($sformatf("starve%0d_addr", i), mem_addr,
                  starve_pat[i] ? 32'h10 : 32'h40);
            tick(); tick(); tick();                         // RESP
            check($sformatf("starve%0d_if_rdy", i), {31'b0, if_ready}, {31'b0, starve_pat[i]});
            check($sformatf("starve%0d_d_rdy", i),  {31'b0, d_ready},  {31'b0, ~starve_pat[i]});
            if (i == 9) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();                                         // IDLE
        end
        tick();
        check("starve_done", {31'b0, busy}, 32'd0);

        // Reset in the WAIT cycle of a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        tick();                                             // ISSUE
        tick();                                             // WAIT
        reset = 1'b0;
        #1;
        check("mid_rst_busy",    {31'b0, busy},    32'd0);
        check("mid_rst_mem_en",  {31'b0, mem_en},  32'd0);
        check("mid_rst_addr",    mem_addr,         32'h0);
        check("mid_rst_d_rdata", d_rdata,          32'h0);
        check("mid_rst_if_rdata", if_rdata,        32'h0);
        d_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst_no_rdy%0d", i), {31'b0, d_ready}, 32'd0);
        end
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;
        fetch_txn("post_rst_fetch", 32'h10, 32'h00A0_0093);

        // Early deassert with address churn after the grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        tick();                                             // cycle 1
        check("churn_addr1", mem_addr, 32'h40);
        d_req  = 1'b0;
        d_addr = 32'h99;
        tick();                                             // cycle 2
        check("churn_addr2", mem_addr, 32'h40);
        tick();                                             // cycle 3
        check("churn_addr3", mem_addr, 32'h40);
        tick();                                             // cycle 4
        check("churn_rdy",   {31'b0, d_ready}, 32'd1);
        check("churn_rdata", d_rdata,          32'hDEAD_BEEF);
        tick();                                             // cycle 5
        check("churn_idle",  {31'b0, busy},    32'd0);
        check("churn_pulse", {31'b0, d_ready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
